// File: rtl/sensor_pattern_gen_pkg.sv
// Shared types and constants for the light-barrier pattern generator.
`default_nettype none

package sensor_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [1:0] AB_IDLE   = 2'b00;
  localparam logic [1:0] AB_BOTH   = 2'b11;
  localparam logic [1:0] AB_A_ONLY = 2'b10;
  localparam logic [1:0] AB_B_ONLY = 2'b01;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Barrier pattern {A,B} shown while in state s for movement direction d.
  function automatic logic [1:0] ab_pattern(input state_t s, input logic d);
    logic [1:0] ab;
    ab = AB_IDLE;
    case (s)
      ST_P1:   ab = (d == DIR_IN) ? AB_A_ONLY : AB_B_ONLY;
      ST_P2:   ab = AB_BOTH;
      ST_P3:   ab = (d == DIR_IN) ? AB_B_ONLY : AB_A_ONLY;
      default: ab = AB_IDLE;
    endcase
    return ab;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_pattern_gen_dwell_timer.sv
// Phase dwell timer: up-counter with synchronous clear and a loadable compare limit.
`default_nettype none

module dwell_timer #(
  parameter int CNT_W = 9
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] limit_in,
  output logic             hit
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_limit;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_limit <= '0;
    end else begin
      if (load) begin
        r_limit <= limit_in;
      end
      if (clear) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign hit = (r_count == r_limit);

endmodule

`default_nettype wire

// File: rtl/sensor_pattern_gen.sv
// Drives barrier lines A/B with one clean entering or exiting vehicle pass per request.
`default_nettype none

module sensor_pattern_gen
  import sensor_pattern_gen_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic               A,
  output logic               B,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int CNT_W = DWELL_W + 1;

  state_t             r_state;
  logic               r_dir;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_hit;
  logic               w_abort_ok;
  logic               w_clear;
  logic               w_load;
  logic [CNT_W-1:0]   w_limit;

  // Phases P1..P3 compare against d; the limit is bumped to d+1 on entry to GAP.
  always_comb begin
    w_abort_ok = abort && ((r_state == ST_P1) || (r_state == ST_P2));
    w_load     = ((r_state == ST_IDLE) && start) || ((r_state == ST_P3) && w_hit);
    w_limit    = (r_state == ST_IDLE) ? {1'b0, dwell} : ({1'b0, r_dwell} + CNT_W'(1));
    w_clear    = (r_state == ST_IDLE) || w_hit || w_abort_ok;
  end

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (w_clear),
    .load     (w_load),
    .limit_in (w_limit),
    .hit      (w_hit)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_IN;
      r_dwell <= '0;
      A       <= 1'b0;
      B       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_dwell <= dwell;
            r_state <= ST_P1;
            {A, B}  <= ab_pattern(ST_P1, dir);
            busy    <= 1'b1;
          end
        end
        ST_P1: begin
          if (w_abort_ok) begin
            r_state <= ST_IDLE;
            {A, B}  <= AB_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (w_hit) begin
            r_state <= ST_P2;
            {A, B}  <= ab_pattern(ST_P2, r_dir);
          end
        end
        ST_P2: begin
          if (w_abort_ok) begin
            r_state <= ST_IDLE;
            {A, B}  <= AB_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (w_hit) begin
            r_state <= ST_P3;
            {A, B}  <= ab_pattern(ST_P3, r_dir);
          end
        end
        // Abort is deliberately ignored from here on: leaving P3 early would itself look like a pass.
        ST_P3: begin
          if (w_hit) begin
            r_state <= ST_GAP;
            {A, B}  <= AB_IDLE;
          end
        end
        ST_GAP: begin
          if (w_hit) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          {A, B}  <= AB_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
